fetch_queue: RTL and testbench
==============================

// Module: fetch_queue
// PURPOSE
//  Instruction buffer between instruction memory and decoder; absorbs decoder stalls.
//  - Holds up to DEPTH fetched words, each tagged with its instruction index (0..31).
//  - Presents words to the decoder in order using a valid/ready handshake.
//  - Predecodes B-type words (opcode 7'b1100011) so the fetch side can hold off until the branch resolves.
//  - Flush on branch redirect discards every queued (wrong-path) word.
// PARAMETERS
//  DATA_W   32  instruction word width
//  IDX_W    5   instruction index width (32-entry instruction memory)
//  DEPTH    4   queue entries; power of 2, >=2
//  PTR_W    2   log2(DEPTH)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous reset, active-low
//  in_valid   in   1       fetch side offers in_instr/in_idx
//  in_ready   out  1       queue accepts this cycle; = !full (registered state only)
//  in_instr   in   DATA_W  fetched instruction word
//  in_idx     in   IDX_W   instruction index of in_instr
//  out_valid  out  1       head entry valid; = !empty
//  out_ready  in   1       decoder consumes head this cycle
//  out_instr  out  DATA_W  head instruction word
//  out_idx    out  IDX_W   head instruction index
//  out_is_br  out  1       head opcode == 7'b1100011
//  br_pending out  1       some queued entry is a branch
//  flush      in   1       discard all entries (branch redirect)
//  count      out  PTR_W+1 current occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - Clears rd_ptr, wr_ptr, count and all valid/branch flags.
//  - Outputs after reset: out_valid=0, in_ready=1, out_is_br=0, br_pending=0, count=0.
//  - out_instr and out_idx read 0 after reset.
//  - Reset in mid-operation drops all contents, exactly like flush.
//  Push:
//  - Occurs when in_valid & in_ready; writes entry[wr_ptr]; wr_ptr wraps at DEPTH.
//  - Branch flag of the entry = (in_instr[6:0]==7'b1100011).
//  Pop:
//  - Occurs when out_valid & out_ready; rd_ptr increments with wrap.
//  Timing:
//  - Latency is 1 cycle: a word pushed at edge N is visible on out_* after edge N.
//  - No combinational bypass: when empty, a word pushed at N is not popped at N.
//  - out_* are driven straight from entry[rd_ptr].
//  Occupancy:
//  - Push only: count+1. Pop only: count-1. Push+pop together: count unchanged, both pointers advance.
//  - Full (count==DEPTH): in_ready=0, so in_valid is ignored even if out_ready=1 that cycle.
//  - Empty: out_valid=0; out_ready is ignored.
//  Flush:
//  - Highest priority after reset. rd_ptr=wr_ptr=0, count=0, flags cleared.
//  - A push or pop offered in the same cycle is dropped; in_ready stays 1 next cycle.
//  Branch tracking:
//  - br_pending is the OR of the branch flags over the valid entries.
//  - Recomputed from registered state; no dependency on in_* in the same cycle.
//  Protocol:
//  - in_valid may drop without a handshake (the fetch side redirects freely).
//  - Holding out_valid once asserted is guaranteed, except across flush.
//  Arithmetic:
//  - Pointers are PTR_W bits and wrap naturally.
//  - count is PTR_W+1 bits and never exceeds DEPTH.
//  - Assertion: no push when full; count==wr_ptr-rd_ptr mod DEPTH unless full.
// STRUCTURE
//  - Shared package constants: OPC_BRANCH=7'b1100011, OPC_LOAD=7'b0000011,
//    OPC_STORE=7'b0100011, OPC_RTYPE=7'b0110011, OPC_ITYPE=7'b0010011, INSTR_W=32, IMEM_IDX_W=5.
//  - Single flat module with storage arrays entry_instr, entry_idx, entry_br.
//  - The predecoder is one compare; no sub-module.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles mid-traffic with count=3.
//     Expect count=0, out_valid=0, in_ready=1, br_pending=0.
//  2. Fill and drain: push idx 0..3 (0x00500093, 0x00108133, 0x002081b3, 0x00310233) with out_ready=0.
//     Expect in_ready=0 and count=4; a 5th offer is not accepted.
//     Then out_ready=1: pops in order idx 0,1,2,3, then out_valid=0.
//  3. Simultaneous push/pop: count=2, push idx 7 with out_ready=1 every cycle for 6 cycles.
//     Expect count stays 2, pointers wrap, output order preserved.
//  4. Full with out_ready=1 and in_valid=1: only the pop occurs; count 4->3.
//     The offered word is accepted on the following cycle.
//  5. Branch flag: push 0x00208463 (beq) at idx 4.
//     Expect br_pending=1, and out_is_br=1 when it reaches the head.
//     After it is popped, br_pending=0.
//  6. Flush: count=3 with flush=1 plus in_valid=1 in the same cycle.
//     Expect count=0, out_valid=0, and the offered word discarded.
//     Next push of idx 9 appears at the head one cycle later.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the instruction fetch queue.
// Opcode encodings are the RV32I major opcodes seen by the predecoder.
package fetch_queue_pkg;

    localparam int unsigned INSTR_W    = 32;
    localparam int unsigned IMEM_IDX_W = 5;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE  = 7'b0010011;

    function automatic logic is_branch(input logic [6:0] opcode);
        return opcode == OPC_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction buffer between instruction memory and decoder.
// Tags each word with its index and tracks queued branches so fetch can hold off.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DATA_W = INSTR_W,
    parameter int unsigned IDX_W  = IMEM_IDX_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [IDX_W-1:0]  in_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_is_br,
    output logic              br_pending,
    input  logic              flush,
    output logic [PTR_W:0]    count
);

    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] entry_instr_q [DEPTH];
    logic [IDX_W-1:0]  entry_idx_q   [DEPTH];
    logic [DEPTH-1:0]  entry_br_q, entry_br_d;
    logic [DEPTH-1:0]  entry_vld_q, entry_vld_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic full, empty, push, pop;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // Flush swallows any handshake offered in the same cycle.
    assign push  = in_valid & ~full & ~flush;
    assign pop   = out_ready & ~empty & ~flush;

    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        entry_vld_d = entry_vld_q;
        entry_br_d  = entry_br_q;
        if (flush) begin
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            entry_vld_d = '0;
            entry_br_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d              = rd_ptr_q + PTR_W'(1);
                entry_vld_d[rd_ptr_q] = 1'b0;
                entry_br_d[rd_ptr_q]  = 1'b0;
            end
            if (push) begin
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
                entry_vld_d[wr_ptr_q] = 1'b1;
                entry_br_d[wr_ptr_q]  = is_branch(in_instr[6:0]);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            entry_vld_q   <= '0;
            entry_br_q    <= '0;
            entry_instr_q <= '{default: '0};
            entry_idx_q   <= '{default: '0};
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            entry_vld_q <= entry_vld_d;
            entry_br_q  <= entry_br_d;
            if (push) begin
                entry_instr_q[wr_ptr_q] <= in_instr;
                entry_idx_q[wr_ptr_q]   <= in_idx;
            end
        end
    end

    assign in_ready   = ~full;
    assign out_valid  = ~empty;
    assign out_instr  = entry_instr_q[rd_ptr_q];
    assign out_idx    = entry_idx_q[rd_ptr_q];
    assign out_is_br  = entry_br_q[rd_ptr_q];
    assign br_pending = |(entry_br_q & entry_vld_q);
    assign count      = count_q;

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(in_valid && in_ready && full));
    a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        full || (count_q == {1'b0, wr_ptr_q - rd_ptr_q}));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, then random traffic against a queue model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, flush;
    logic [31:0] in_instr;
    logic [4:0]  in_idx;
    logic        in_ready, out_valid, out_is_br, br_pending;
    logic [31:0] out_instr;
    logic [4:0]  out_idx;
    logic [2:0]  count;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_idx     (in_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_idx    (out_idx),
        .out_is_br  (out_is_br),
        .br_pending (br_pending),
        .flush      (flush),
        .count      (count)
    );

    typedef struct {
        bit          rst_n, flush, in_valid, out_ready;
        logic [31:0] instr;
        logic [4:0]  idx;
        int          cnt;
        bit          ov, ir, bp, chk;
        logic [31:0] e_instr;
        logic [4:0]  e_idx;
        bit          e_br;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input bit r, input bit f, input bit iv, input bit ordy,
                               input logic [31:0] ins, input logic [4:0] ix, input int c,
                               input bit ov, input bit ir, input bit bp, input bit ck,
                               input logic [31:0] ei, input logic [4:0] ex, input bit eb);
        vec_t t;
        t.rst_n = r;  t.flush = f;  t.in_valid = iv;  t.out_ready = ordy;
        t.instr = ins;  t.idx = ix;  t.cnt = c;  t.ov = ov;  t.ir = ir;  t.bp = bp;
        t.chk = ck;  t.e_instr = ei;  t.e_idx = ex;  t.e_br = eb;
        return t;
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit f, input bit iv, input bit ordy,
                         input logic [31:0] ins, input logic [4:0] ix);
        rst_n = r;  flush = f;  in_valid = iv;  out_ready = ordy;
        in_instr = ins;  in_idx = ix;
    endtask

    // Reference model: plain queue of {idx, instr}.
    logic [36:0] mq[$];
    bit          zero_out;

    function automatic bit model_br_pending();
        foreach (mq[i]) if (mq[i][6:0] == 7'b1100011) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [31:0] ri;
        bit          rr, rf, riv, ror;
        logic [4:0]  rx;
        int          sz;

        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset, then reset mid-traffic at count=3
        vecs.push_back(v(0,0,0,0,32'h0,0,            0,0,1,0,1,32'h0,0,0));
        vecs.push_back(v(1,0,1,0,32'h00100013,1,     1,1,1,0,1,32'h00100013,1,0));
        vecs.push_back(v(1,0,1,0,32'h00208463,2,     2,1,1,1,1,32'h00100013,1,0));
        vecs.push_back(v(1,0,1,0,32'h00300013,3,     3,1,1,1,1,32'h00100013,1,0));
        vecs.push_back(v(0,0,1,1,32'h00400013,4,     0,0,1,0,1,32'h0,0,0));
        vecs.push_back(v(0,0,1,1,32'h00400013,4,     0,0,1,0,1,32'h0,0,0));
        // Fill, refused fifth offer, drain in order
        vecs.push_back(v(1,0,1,0,32'h00500093,0,     1,1,1,0,1,32'h00500093,0,0));
        vecs.push_back(v(1,0,1,0,32'h00108133,1,     2,1,1,0,1,32'h00500093,0,0));
        vecs.push_back(v(1,0,1,0,32'h002081b3,2,     3,1,1,0,1,32'h00500093,0,0));
        vecs.push_back(v(1,0,1,0,32'h00310233,3,     4,1,0,0,1,32'h00500093,0,0));
        vecs.push_back(v(1,0,1,0,32'h00000013,5,     4,1,0,0,1,32'h00500093,0,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            3,1,1,0,1,32'h00108133,1,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            2,1,1,0,1,32'h002081b3,2,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            1,1,1,0,1,32'h00310233,3,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            0,0,1,0,0,32'h0,0,0));
        // Full with pop offered: only the pop happens, offer taken next cycle
        vecs.push_back(v(1,0,1,0,32'h00a00013,10,    1,1,1,0,1,32'h00a00013,10,0));
        vecs.push_back(v(1,0,1,0,32'h00b00013,11,    2,1,1,0,1,32'h00a00013,10,0));
        vecs.push_back(v(1,0,1,0,32'h00c00013,12,    3,1,1,0,1,32'h00a00013,10,0));
        vecs.push_back(v(1,0,1,0,32'h00d00013,13,    4,1,0,0,1,32'h00a00013,10,0));
        vecs.push_back(v(1,0,1,1,32'h00e00013,14,    3,1,1,0,1,32'h00b00013,11,0));
        vecs.push_back(v(1,0,1,0,32'h00e00013,14,    4,1,0,0,1,32'h00b00013,11,0));
        // Down to count=2, then push+pop together for 6 cycles
        vecs.push_back(v(1,0,0,1,32'h0,0,            3,1,1,0,1,32'h00c00013,12,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            2,1,1,0,1,32'h00d00013,13,0));
        vecs.push_back(v(1,0,1,1,32'h00170013,7,     2,1,1,0,1,32'h00e00013,14,0));
        vecs.push_back(v(1,0,1,1,32'h00270013,7,     2,1,1,0,1,32'h00170013,7,0));
        vecs.push_back(v(1,0,1,1,32'h00370013,7,     2,1,1,0,1,32'h00270013,7,0));
        vecs.push_back(v(1,0,1,1,32'h00470013,7,     2,1,1,0,1,32'h00370013,7,0));
        vecs.push_back(v(1,0,1,1,32'h00570013,7,     2,1,1,0,1,32'h00470013,7,0));
        vecs.push_back(v(1,0,1,1,32'h00670013,7,     2,1,1,0,1,32'h00570013,7,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            1,1,1,0,1,32'h00670013,7,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            0,0,1,0,0,32'h0,0,0));
        // Branch tracking
        vecs.push_back(v(1,0,1,0,32'h00300013,3,     1,1,1,0,1,32'h00300013,3,0));
        vecs.push_back(v(1,0,1,0,32'h00208463,4,     2,1,1,1,1,32'h00300013,3,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            1,1,1,1,1,32'h00208463,4,1));
        vecs.push_back(v(1,0,0,1,32'h0,0,            0,0,1,0,0,32'h0,0,0));
        // Flush with a push offered in the same cycle
        vecs.push_back(v(1,0,1,0,32'h01400013,20,    1,1,1,0,1,32'h01400013,20,0));
        vecs.push_back(v(1,0,1,0,32'h01500013,21,    2,1,1,0,1,32'h01400013,20,0));
        vecs.push_back(v(1,0,1,0,32'h00208463,22,    3,1,1,1,1,32'h01400013,20,0));
        vecs.push_back(v(1,1,1,1,32'h01700013,23,    0,0,1,0,0,32'h0,0,0));
        vecs.push_back(v(1,0,1,0,32'h00900013,9,     1,1,1,0,1,32'h00900013,9,0));
        vecs.push_back(v(1,0,0,1,32'h0,0,            0,0,1,0,0,32'h0,0,0));

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].flush, vecs[i].in_valid, vecs[i].out_ready,
                  vecs[i].instr, vecs[i].idx);
            @(posedge clk);
            @(negedge clk);
            check("count", i, 32'(count), 32'(vecs[i].cnt));
            check("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            check("in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
            check("br_pending", i, 32'(br_pending), 32'(vecs[i].bp));
            if (vecs[i].chk) begin
                check("out_instr", i, out_instr, vecs[i].e_instr);
                check("out_idx", i, 32'(out_idx), 32'(vecs[i].e_idx));
                check("out_is_br", i, 32'(out_is_br), 32'(vecs[i].e_br));
            end
        end

        // Random traffic; table leaves the queue empty with nothing zero-guaranteed
        mq.delete();
        zero_out = 1'b0;
        for (int s = 0; s < 3000; s++) begin
            rr  = ($urandom_range(99) != 0);
            rf  = ($urandom_range(29) == 0);
            riv = ($urandom_range(9) < 7);
            ror = ($urandom_range(9) < 5);
            ri  = $urandom;
            if ($urandom_range(3) == 0) ri[6:0] = 7'b1100011;
            rx  = 5'($urandom_range(31));
            drive(rr, rf, riv, ror, ri, rx);
            @(posedge clk);
            sz = mq.size();
            if (!rr) begin
                mq.delete();
                zero_out = 1'b1;
            end else if (rf) begin
                mq.delete();
            end else begin
                if (ror && sz > 0) void'(mq.pop_front());
                if (riv && sz < 4) begin
                    mq.push_back({rx, ri});
                    zero_out = 1'b0;
                end
            end
            @(negedge clk);
            check("rnd_count", s, 32'(count), 32'(mq.size()));
            check("rnd_out_valid", s, 32'(out_valid), 32'(mq.size() > 0));
            check("rnd_in_ready", s, 32'(in_ready), 32'(mq.size() < 4));
            check("rnd_br_pending", s, 32'(br_pending), 32'(model_br_pending()));
            if (mq.size() > 0) begin
                check("rnd_out_instr", s, out_instr, mq[0][31:0]);
                check("rnd_out_idx", s, 32'(out_idx), 32'(mq[0][36:32]));
                check("rnd_out_is_br", s, 32'(out_is_br),
                      32'(mq[0][6:0] == 7'b1100011));
            end else if (zero_out) begin
                check("rnd_reset_instr", s, out_instr, 32'h0);
                check("rnd_reset_idx", s, 32'(out_idx), 32'h0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
